// File: rtl/audio_loop_ram_if.sv
// Host memory-mapped port of the audio loop RAM.
interface audio_loop_ram_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 18
);
    logic [ADDR_W-1:0]   s1_address;
    logic                s1_chipselect;
    logic                s1_clken;
    logic                s1_write;
    logic [DATA_W/8-1:0] s1_byteenable;
    logic [DATA_W-1:0]   s1_writedata;
    logic [DATA_W-1:0]   s1_readdata;

    modport master (
        output s1_address, s1_chipselect, s1_clken, s1_write,
        output s1_byteenable, s1_writedata,
        input  s1_readdata
    );

    modport slave (
        input  s1_address, s1_chipselect, s1_clken, s1_write,
        input  s1_byteenable, s1_writedata,
        output s1_readdata
    );
endinterface

// File: rtl/audio_loop_ram.sv
// Shared single-port sample RAM: host port plus record/playback loop engines.
module audio_loop_ram #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 18,
    parameter int CHANNELS = 2
) (
    input  logic                         clk_clk,
    input  logic                         reset_reset,
    audio_loop_ram_if.slave              host,
    input  logic [ADDR_W-1:0]            loop_frames,
    input  logic                         rec_en,
    input  logic                         rec_valid,
    input  logic [CHANNELS*DATA_W-1:0]   rec_data,
    output logic                         rec_ready,
    output logic                         rec_wrap,
    input  logic                         play_en,
    input  logic                         play_req,
    output logic                         play_valid,
    output logic [CHANNELS*DATA_W-1:0]   play_data,
    output logic                         play_overrun
);
    localparam int FW   = CHANNELS * DATA_W;
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int NB   = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, REC, PLAY, PLAY_DONE} state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d, rd_idx_q, rd_idx_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] lim_q, lim_d;
    logic [FW-1:0]     frame_q, frame_d, play_data_q, play_data_d;
    logic              rd_vld_q, rd_vld_d;
    logic              pend_q, pend_d, ovr_q, ovr_d;
    logic              pvalid_q, pvalid_d, wrap_q, wrap_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] eng_q;
    logic [DATA_W-1:0] eng_wdata;
    logic [ADDR_W-1:0] eng_addr, lf, wr_next, rd_next;
    logic              host_acc, eng_we, eng_re, last_ch;
    logic              play_set, pend_clr;

    assign host_acc  = host.s1_chipselect && host.s1_clken;
    // Reset gate keeps every output low while reset is held.
    assign rec_ready = rec_en && state_q == IDLE && !pend_q && !reset_reset;

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        rd_idx_d    = rd_idx_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        lim_d       = lim_q;
        frame_d     = frame_q;
        play_data_d = play_data_q;
        rd_vld_d    = 1'b0;
        pvalid_d    = 1'b0;
        wrap_d      = 1'b0;
        rdata_d     = rdata_q;
        eng_we      = 1'b0;
        eng_re      = 1'b0;

        last_ch   = ch_q == CH_W'(CHANNELS - 1);
        lf        = (loop_frames == '0) ? ADDR_W'(1) : loop_frames;
        wr_next   = wr_ptr_q + ADDR_W'(CHANNELS);
        rd_next   = rd_ptr_q + ADDR_W'(CHANNELS);
        eng_addr  = ((state_q == REC) ? wr_ptr_q : rd_ptr_q) + ADDR_W'(ch_q);
        eng_wdata = frame_q[ch_q*DATA_W +: DATA_W];

        play_set = play_req && play_en;
        pend_clr = state_q == IDLE && pend_q;
        pend_d   = play_set || (pend_q && !pend_clr);
        ovr_d    = ovr_q || (play_set && pend_q && !pend_clr);

        // Read data lands one cycle after issue; stage it per channel.
        if (rd_vld_q)
            frame_d[rd_idx_q*DATA_W +: DATA_W] = eng_q;

        unique case (state_q)
            IDLE: begin
                lim_d = lf * ADDR_W'(CHANNELS);
                ch_d  = '0;
                if (pend_q) begin
                    state_d = PLAY;
                end else if (rec_valid && rec_ready) begin
                    frame_d = rec_data;
                    state_d = REC;
                end
            end
            REC: if (!host_acc) begin
                eng_we = 1'b1;
                ch_d   = ch_q + CH_W'(1);
                if (last_ch) begin
                    ch_d    = '0;
                    state_d = IDLE;
                    if (wr_next == lim_q) begin
                        wr_ptr_d = '0;
                        wrap_d   = 1'b1;
                    end else begin
                        wr_ptr_d = wr_next;
                    end
                end
            end
            PLAY: if (!host_acc) begin
                eng_re   = 1'b1;
                rd_vld_d = 1'b1;
                rd_idx_d = ch_q;
                ch_d     = ch_q + CH_W'(1);
                if (last_ch) begin
                    ch_d    = '0;
                    state_d = PLAY_DONE;
                end
            end
            PLAY_DONE: begin
                play_data_d = frame_d;
                pvalid_d    = 1'b1;
                rd_ptr_d    = (rd_next == lim_q) ? '0 : rd_next;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (host_acc && !host.s1_write)
            rdata_d = mem[host.s1_address];
    end

    always_ff @(posedge clk_clk) begin
        if (host_acc && host.s1_write) begin
            for (int b = 0; b < NB; b++)
                if (host.s1_byteenable[b])
                    mem[host.s1_address][b*8 +: 8] <= host.s1_writedata[b*8 +: 8];
        end else if (eng_we) begin
            mem[eng_addr] <= eng_wdata;
        end
        if (eng_re)
            eng_q <= mem[eng_addr];
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            rd_idx_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            lim_q       <= '0;
            frame_q     <= '0;
            play_data_q <= '0;
            rd_vld_q    <= 1'b0;
            pend_q      <= 1'b0;
            ovr_q       <= 1'b0;
            pvalid_q    <= 1'b0;
            wrap_q      <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            rd_idx_q    <= rd_idx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            lim_q       <= lim_d;
            frame_q     <= frame_d;
            play_data_q <= play_data_d;
            rd_vld_q    <= rd_vld_d;
            pend_q      <= pend_d;
            ovr_q       <= ovr_d;
            pvalid_q    <= pvalid_d;
            wrap_q      <= wrap_d;
            rdata_q     <= rdata_d;
        end
    end

    assign host.s1_readdata = rdata_q;
    assign rec_wrap         = wrap_q;
    assign play_valid       = pvalid_q;
    assign play_data        = play_data_q;
    assign play_overrun     = ovr_q;
endmodule

// File: tb/tb_audio_loop_ram.sv
// Bench for audio_loop_ram: directed steps plus random frames against
// a frame-level model of the loop buffer.
module tb_audio_loop_ram;
    localparam int DW = 16;
    localparam int AW = 18;
    localparam int CH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] loop_frames;
    logic          rec_en, rec_valid, rec_ready, rec_wrap;
    logic [CH*DW-1:0] rec_data, play_data;
    logic          play_en, play_req, play_valid, play_overrun;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] mm [0:63];
    int wp, rp, L;

    audio_loop_ram_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    audio_loop_ram #(.DATA_W(DW), .ADDR_W(AW), .CHANNELS(CH)) dut (
        .clk_clk      (clk),
        .reset_reset  (rst),
        .host         (bus),
        .loop_frames  (loop_frames),
        .rec_en       (rec_en),
        .rec_valid    (rec_valid),
        .rec_data     (rec_data),
        .rec_ready    (rec_ready),
        .rec_wrap     (rec_wrap),
        .play_en      (play_en),
        .play_req     (play_req),
        .play_valid   (play_valid),
        .play_data    (play_data),
        .play_overrun (play_overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: frame n of the loop lives at words n*CH .. n*CH+CH-1.
    task automatic m_rec(input logic [CH*DW-1:0] f, output bit wrap);
        for (int c = 0; c < CH; c++)
            mm[wp + c] = f[c*DW +: DW];
        wp += CH;
        wrap = (wp == L * CH);
        if (wrap) wp = 0;
    endtask

    task automatic m_play(output logic [CH*DW-1:0] f);
        for (int c = 0; c < CH; c++)
            f[c*DW +: DW] = mm[rp + c];
        rp += CH;
        if (rp == L * CH) rp = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        wp = 0;
        rp = 0;
    endtask

    task automatic hwrite(input int a, input logic [DW-1:0] d,
                          input logic [DW/8-1:0] be);
        bus.s1_chipselect = 1'b1;
        bus.s1_clken      = 1'b1;
        bus.s1_write      = 1'b1;
        bus.s1_address    = AW'(a);
        bus.s1_writedata  = d;
        bus.s1_byteenable = be;
        tick();
        bus.s1_chipselect = 1'b0;
        bus.s1_write      = 1'b0;
        for (int b = 0; b < DW/8; b++)
            if (be[b]) mm[a][b*8 +: 8] = d[b*8 +: 8];
    endtask

    task automatic hread(input int a, input string tag);
        bus.s1_chipselect = 1'b1;
        bus.s1_clken      = 1'b1;
        bus.s1_write      = 1'b0;
        bus.s1_address    = AW'(a);
        tick();
        bus.s1_chipselect = 1'b0;
        chk(tag, bus.s1_readdata, mm[a]);
    endtask

    task automatic do_rec(input logic [CH*DW-1:0] f, input string tag);
        int n;
        bit w;
        n = 0;
        while (!rec_ready && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_ready"}, rec_ready, 1);
        rec_valid = 1'b1;
        rec_data  = f;
        tick();
        rec_valid = 1'b0;
        m_rec(f, w);
        repeat (CH) tick();
        chk({tag, "_wrap"}, rec_wrap, w);
    endtask

    task automatic do_play(input int stall, input string tag);
        int lat;
        logic [CH*DW-1:0] exp;
        play_req = 1'b1;
        tick();
        play_req = 1'b0;
        lat = 0;
        if (stall > 0) begin
            tick();
            lat++;
            bus.s1_chipselect = 1'b1;
            bus.s1_clken      = 1'b1;
            bus.s1_write      = 1'b0;
            bus.s1_address    = '0;
            repeat (stall) begin
                tick();
                lat++;
            end
            bus.s1_chipselect = 1'b0;
        end
        while (!play_valid && lat < 60) begin
            tick();
            lat++;
        end
        m_play(exp);
        chk({tag, "_lat"}, lat, CH + 2 + stall);
        chk({tag, "_data"}, play_data, exp);
        tick();
        chk({tag, "_pulse"}, {play_valid, play_data}, {1'b0, exp});
    endtask

    initial begin
        logic [CH*DW-1:0] f, got;
        int cnt, n, op;
        bit w;

        rst = 1'b1;
        loop_frames = AW'(3);
        L = 3;
        rec_en = 1'b1;
        rec_valid = 1'b0;
        rec_data = '0;
        play_en = 1'b1;
        play_req = 1'b0;
        bus.s1_chipselect = 1'b0;
        bus.s1_clken = 1'b0;
        bus.s1_write = 1'b0;
        bus.s1_address = '0;
        bus.s1_byteenable = '0;
        bus.s1_writedata = '0;
        #2;
        chk("reset_outs", {rec_ready, rec_wrap, play_valid, play_overrun,
                           play_data, bus.s1_readdata}, '0);
        tick();
        tick();
        rst = 1'b0;
        wp = 0;
        rp = 0;

        // Byte-lane write then registered read.
        hwrite(5, 16'hBEEF, 2'b11);
        hwrite(5, 16'h12AB, 2'b10);
        hread(5, "host_be");
        chk("host_be_val", bus.s1_readdata, 16'h12EF);
        tick();
        chk("host_hold", bus.s1_readdata, 16'h12EF);

        // Three frames fill a 3-frame loop; wrap on the third.
        do_rec({16'd2, 16'd1}, "rec1");
        do_rec({16'd4, 16'd3}, "rec2");
        do_rec({16'd6, 16'd5}, "rec3");
        for (int i = 0; i < 4; i++) begin
            do_play(0, $sformatf("play%0d", i));
            repeat (6) tick();
        end
        do_rec({16'd8, 16'd7}, "rec4");
        for (int a = 0; a < 6; a++)
            hread(a, $sformatf("ram%0d", a));
        chk("ram_pattern", {mm[0], mm[1], mm[2], mm[3], mm[4], mm[5]},
            {16'd7, 16'd8, 16'd3, 16'd4, 16'd5, 16'd6});

        do_play(3, "stall");

        // Play requests arriving with the record accept and during REC.
        n = 0;
        while (!rec_ready && n < 50) begin
            tick();
            n++;
        end
        f = {16'($urandom), 16'($urandom)};
        rec_valid = 1'b1;
        rec_data  = f;
        play_req  = 1'b1;
        tick();
        rec_valid = 1'b0;
        m_rec(f, w);
        tick();
        tick();
        play_req = 1'b0;
        chk("ovr_set", play_overrun, 1);
        m_play(f);
        cnt = 0;
        got = '0;
        repeat (30) begin
            tick();
            if (play_valid) begin
                cnt++;
                got = play_data;
            end
        end
        chk("ovr_frames", cnt, 1);
        chk("ovr_data", got, f);
        chk("ovr_sticky", play_overrun, 1);

        // Async reset in the middle of a playback.
        play_req = 1'b1;
        tick();
        play_req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("async_rst", {rec_ready, rec_wrap, play_valid, play_overrun,
                          play_data, bus.s1_readdata}, '0);
        tick();
        rst = 1'b0;
        wp = 0;
        rp = 0;
        chk("rst_noplay", play_valid, 0);
        do_play(0, "post_rst");

        // Random mix with a random loop length.
        L = $urandom_range(1, 3);
        loop_frames = AW'(L);
        do_reset();
        for (int i = 0; i < 16; i++) begin
            op = $urandom_range(0, 2);
            if (op == 0) begin
                do_rec({16'($urandom), 16'($urandom)}, $sformatf("rnd_rec%0d", i));
            end else if (op == 1) begin
                do_play(0, $sformatf("rnd_play%0d", i));
            end else begin
                n = $urandom_range(0, 5);
                hwrite(n, 16'($urandom), 2'($urandom));
                hread(n, $sformatf("rnd_host%0d", i));
            end
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
